serial_sbox_driver: RTL and testbench
=====================================

Name: serial_sbox_driver

Overview:
- Byte-side front end for the bit-serial S-box shift register.
- Accepts bytes on a valid/ready interface and streams each one MSB-first onto the register's serial input.
- Pulses the register's S-box load control on the last bit of each byte, then reassembles the register's serial output into result bytes.
- Frames are NUM_BYTES long; one driver serves one serial lane.

Parameters:
NUM_BYTES, 16, bytes per frame (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  byte to process
in_valid  input  1  in_data valid
in_ready  output  1  holding register empty
sub_mode  input  1  1 = apply S-box, 0 = bypass; sampled at frame start
ser_bit  output  1  serial bit to S-box register input
sbox_en  output  1  S-box parallel-load control to register
ser_ret  input  1  serial bit from S-box register output
out_data  output  8  result byte
out_valid  output  1  one-cycle pulse, out_data valid
busy  output  1  frame in progress
err_underrun  output  1  sticky, byte missing at slot boundary
err_clr  input  1  clears err_underrun

Behaviour:
- Reset values: all outputs 0 except in_ready = 1; state IDLE; holding register empty.
- Reset is asynchronous and may occur mid-frame; the frame is abandoned with no further out_valid.
- Holding register (1 byte):
  - Accepts a byte when in_valid && in_ready, in any state.
  - in_ready = !hold_full.
- FSM IDLE -> SHIFT -> FLUSH -> IDLE. busy = (state != IDLE).
- IDLE:
  - ser_bit = 0, sbox_en = 0.
  - If hold_full: move the held byte to tx_shift, latch sub_mode, set slot = 0 and bit_cnt = 0, go to SHIFT.
  - Back-to-back frames have at least 1 IDLE cycle.
- SHIFT (slots 0..NUM_BYTES-1, 8 cycles each):
  - ser_bit and sbox_en are registered outputs.
  - On slot cycle b, ser_bit = byte bit 7-b.
  - sbox_en = latched sub_mode on cycle b = 7 only; otherwise 0.
- Slot boundary (cycle 7 of a slot, slot < NUM_BYTES-1):
  - If hold_full: load the next byte for the following cycle and free the holding register.
  - If not hold_full: set err_underrun and go to IDLE (abort).
- FLUSH (8 cycles after the last slot):
  - ser_bit = 0, sbox_en = 0.
  - Return to IDLE after cycle 7.
- Return path:
  - Byte k's result appears on ser_ret during slot k+1 (FLUSH for the last byte), MSB first.
  - The S-box register loads its result at the edge ending slot k, so ser_ret on cycle b = result bit 7-b.
  - ser_ret during slot 0 is stale and discarded.
  - In bypass, the result equals the input byte.
- Capture:
  - ser_ret is sampled every cycle of slots 1..NUM_BYTES-1 and FLUSH into rx_shift (shift left, LSB in).
  - At the edge ending each capture slot: out_data = the assembled byte, out_valid = 1 for one cycle.
- Timing: first out_valid is 16 cycles after the first ser_bit cycle; then one every 8 cycles; NUM_BYTES outputs per frame.
- Abort: the byte completing on the abort edge is still emitted; no further outputs from that frame.
- err_underrun:
  - Sticky until err_clr.
  - Simultaneous set and err_clr: set wins.
  - Does not block new frames.
- Counter widths: bit_cnt is 3 bits and wraps 7 -> 0. slot is $clog2(NUM_BYTES+1) bits.

Optional Feature:
FRAME_CNT_EN:
- Defined: adds output frame_cnt[15:0], reset 0.
  - Increments on the FLUSH -> IDLE transition, i.e. each completed frame.
  - Wraps 0xFFFF -> 0.
  - Aborted frames do not count.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Bypass: NUM_BYTES=4, sub_mode=0, in_valid held, bytes 0x01,0x80,0xA5,0xFF, with ser_ret driven by a bit-serial S-box register model -> out_data 0x01,0x80,0xA5,0xFF; first out_valid 16 cycles after the first ser_bit cycle, then every 8.
- S-box: sub_mode=1, bytes 0x00,0x53,0x01,0xFF with an AES S-box model -> 0x63,0xED,0x7C,0x16; sbox_en high exactly on cycle 7 of each slot, never in FLUSH.
- Underrun: NUM_BYTES=4, supply only 2 bytes -> err_underrun=1 at the end of slot 1; exactly 1 output (byte 0); busy drops. Asserting err_clr then clears err_underrun.
- Reset mid-frame: rst_n low at slot 2 cycle 3 -> all outputs at reset values immediately; after release, a fresh 4-byte frame gives correct outputs.
- Back-to-back: 8 bytes streamed, NUM_BYTES=4 -> 8 correct outputs; busy low for exactly 1 cycle between frames; in_ready backpressure holds in_data without loss.
- FRAME_CNT_EN: 3 complete frames plus 1 aborted frame -> frame_cnt = 3.

Source files
------------

// File: rtl/serial_sbox_driver.sv
// Byte-side front end for a bit-serial S-box shift register: streams bytes MSB-first, reassembles results.
// Define FRAME_CNT_EN to add the frame_cnt output that counts completed frames.
module serial_sbox_driver #(
  parameter int NUM_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sub_mode,
  output logic        ser_bit,
  output logic        sbox_en,
  input  logic        ser_ret,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        busy,
  output logic        err_underrun,
  input  logic        err_clr
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int SW = $clog2(NUM_BYTES + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] slot;
  logic [2:0]    bit_cnt;
  logic [7:0]    hold;
  logic          hold_full;
  logic [6:0]    tx_shift;
  logic [6:0]    rx_shift;
  logic          mode;

  logic accept;
  logic start;
  logic slot_end;
  logic load_next;
  logic abort;
  logic capture;

  assign accept    = in_valid && !hold_full;
  assign start     = (state == IDLE) && hold_full;
  assign slot_end  = (state == SHIFT) && (bit_cnt == 3'd7);
  assign load_next = slot_end && (slot != LAST_SLOT) && hold_full;
  assign abort     = slot_end && (slot != LAST_SLOT) && !hold_full;
  // Slot 0 return data is stale; every later slot and the flush carry a result byte.
  assign capture   = ((state == SHIFT) && (slot != '0)) || (state == FLUSH);

  assign in_ready = !hold_full;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= in_data;
      hold_full <= 1'b1;
    end else if (start || load_next) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      slot     <= '0;
      bit_cnt  <= 3'd0;
      tx_shift <= 7'd0;
      mode     <= 1'b0;
      ser_bit  <= 1'b0;
      sbox_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sbox_en <= 1'b0;
          if (hold_full) begin
            state    <= SHIFT;
            mode     <= sub_mode;
            slot     <= '0;
            bit_cnt  <= 3'd0;
            ser_bit  <= hold[7];
            tx_shift <= hold[6:0];
          end else begin
            ser_bit <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt != 3'd7) begin
            bit_cnt  <= bit_cnt + 3'd1;
            ser_bit  <= tx_shift[6];
            tx_shift <= {tx_shift[5:0], 1'b0};
            // Register loads its S-box result on the edge that ends the slot.
            sbox_en  <= mode && (bit_cnt == 3'd6);
          end else begin
            bit_cnt <= 3'd0;
            sbox_en <= 1'b0;
            if (slot == LAST_SLOT) begin
              state   <= FLUSH;
              ser_bit <= 1'b0;
            end else if (load_next) begin
              slot     <= slot + SW'(1);
              ser_bit  <= hold[7];
              tx_shift <= hold[6:0];
            end else begin
              state   <= IDLE;
              ser_bit <= 1'b0;
            end
          end
        end
        FLUSH: begin
          ser_bit <= 1'b0;
          sbox_en <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ser_bit <= 1'b0;
          sbox_en <= 1'b0;
          bit_cnt <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift  <= 7'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (capture) begin
        rx_shift <= {rx_shift[5:0], ser_ret};
        if (bit_cnt == 3'd7) begin
          out_data  <= {rx_shift, ser_ret};
          out_valid <= 1'b1;
        end
      end
    end
  end

  // A new underrun outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underrun <= 1'b0;
    end else if (abort) begin
      err_underrun <= 1'b1;
    end else if (err_clr) begin
      err_underrun <= 1'b0;
    end
  end

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
    end else if ((state == FLUSH) && (bit_cnt == 3'd7)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_sbox_driver.sv
// Self-checking bench for serial_sbox_driver with a bit-serial AES S-box register model on the return path.
// Covers FRAME_CNT_EN when that macro is defined.
module tb_serial_sbox_driver;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sub_mode;
  logic       ser_bit;
  logic       sbox_en;
  logic       ser_ret;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       err_underrun;
  logic       err_clr;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  serial_sbox_driver #(.NUM_BYTES(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sub_mode(sub_mode),
    .ser_bit(ser_bit),
    .sbox_en(sbox_en),
    .ser_ret(ser_ret),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy),
    .err_underrun(err_underrun),
    .err_clr(err_clr)
`ifdef FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // AES S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'd0;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'd0 && gmul(x, 8'(y)) == 8'd1) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] ref_result(input logic m, input logic [7:0] b);
    return m ? aes_sbox(b) : b;
  endfunction

  // Serial S-box register: shifts ser_bit in, parallel-loads S(byte) when sbox_en is high.
  logic [7:0] sreg;
  assign ser_ret = sreg[7];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sreg <= 8'd0;
    else if (sbox_en) sreg <= aes_sbox({sreg[6:0], ser_bit});
    else sreg <= {sreg[6:0], ser_bit};
  end

  int n_checks = 0;
  int n_fail = 0;
  int frames_done = 0;

  int         cyc = 0;
  logic       prev_busy = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] out_q[$];
  int         out_t[$];
  int         en_t[$];
  int         start_t[$];
  int         fall_t[$];
  int         err_t[$];
  logic [7:0] exp_data[$];
  int         exp_t[$];
  int         exp_en[$];
  int         exp_err[$];

  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      out_q.push_back(out_data);
      out_t.push_back(cyc);
    end
    if (sbox_en) en_t.push_back(cyc);
    if (busy && !prev_busy) start_t.push_back(cyc);
    if (!busy && prev_busy) fall_t.push_back(cyc);
    if (err_underrun && !prev_err) err_t.push_back(cyc);
    prev_busy = busy;
    prev_err = err_underrun;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearRecords();
    out_q.delete(); out_t.delete(); en_t.delete(); start_t.delete();
    fall_t.delete(); err_t.delete(); exp_data.delete(); exp_t.delete();
    exp_en.delete(); exp_err.delete();
  endtask

  task automatic checkFrameCnt();
`ifdef FRAME_CNT_EN
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(frames_done));
`endif
  endtask

  task automatic sendByte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] bytes[$], input int max_gap, input bit flip);
    bit ok;
    int gap;
    for (int i = 0; i < bytes.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      sendByte(bytes[i], ok);
      checkOutput($sformatf("byte %0d accepted", i), 32'(ok), 32'd1);
      if (flip && i == 1) sub_mode = ~sub_mode;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 4 && !busy; i++) @(negedge clk);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    checkOutput({name, " frame ends"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Expected behaviour of one frame of k supplied bytes, anchored at its first busy cycle.
  task automatic buildFrame(input int fidx, input logic m, input int k, input logic [7:0] expb[$]);
    int s;
    int nslots;
    int nout;
    if (fidx >= start_t.size()) begin
      checkOutput($sformatf("frame %0d started", fidx), 32'(start_t.size()), 32'(fidx + 1));
      return;
    end
    s = start_t[fidx];
    nslots = (k < N) ? k : N;
    nout = (k < N) ? k - 1 : N;
    for (int j = 0; j < nout; j++) begin
      exp_data.push_back(expb[j]);
      exp_t.push_back(s + 16 + 8 * j);
    end
    if (m) for (int j = 0; j < nslots; j++) exp_en.push_back(s + 7 + 8 * j);
    if (k < N) exp_err.push_back(s + 8 * k);
  endtask

  task automatic compareRun(input string name);
    checkOutput({name, " out count"}, 32'(out_q.size()), 32'(exp_data.size()));
    for (int j = 0; j < out_q.size() && j < exp_data.size(); j++) begin
      checkOutput($sformatf("%s out_data[%0d]", name, j), 32'(out_q[j]), 32'(exp_data[j]));
      checkOutput($sformatf("%s out_valid cycle[%0d]", name, j), 32'(out_t[j]), 32'(exp_t[j]));
    end
    checkOutput({name, " sbox_en count"}, 32'(en_t.size()), 32'(exp_en.size()));
    for (int j = 0; j < en_t.size() && j < exp_en.size(); j++)
      checkOutput($sformatf("%s sbox_en cycle[%0d]", name, j), 32'(en_t[j]), 32'(exp_en[j]));
    checkOutput({name, " err rise count"}, 32'(err_t.size()), 32'(exp_err.size()));
    for (int j = 0; j < err_t.size() && j < exp_err.size(); j++)
      checkOutput($sformatf("%s err rise cycle[%0d]", name, j), 32'(err_t[j]), 32'(exp_err[j]));
    clearRecords();
  endtask

  task automatic pulseErrClr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic       m;
    logic [7:0] din[4];
    logic [7:0] dout[4];
  } vec_t;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       vecs[3];
    logic [7:0] bq[$];
    logic [7:0] eq[$];
    logic [7:0] eq2[$];
    logic       m;
    int         k;

    vecs[0] = '{m: 1'b0, din: '{8'h01, 8'h80, 8'hA5, 8'hFF}, dout: '{8'h01, 8'h80, 8'hA5, 8'hFF}};
    vecs[1] = '{m: 1'b1, din: '{8'h00, 8'h53, 8'h01, 8'hFF}, dout: '{8'h63, 8'hED, 8'h7C, 8'h16}};
    vecs[2] = '{m: 1'b1, din: '{8'h10, 8'h11, 8'h02, 8'h03}, dout: '{8'hCA, 8'h82, 8'h77, 8'h7B}};

    rst_n = 1'b0; in_data = 8'd0; in_valid = 1'b0; sub_mode = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset ser_bit", 32'(ser_bit), 32'd0);
    checkOutput("reset sbox_en", 32'(sbox_en), 32'd0);
    checkOutput("reset err_underrun", 32'(err_underrun), 32'd0);
    checkFrameCnt();
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clearRecords();

    $display("[TB] table vectors");
    for (int v = 0; v < 3; v++) begin
      bq.delete(); eq.delete();
      for (int j = 0; j < 4; j++) begin
        bq.push_back(vecs[v].din[j]);
        eq.push_back(vecs[v].dout[j]);
      end
      sub_mode = vecs[v].m;
      applyStimulus(bq, 0, 1'b0);
      waitIdle($sformatf("vec%0d", v));
      buildFrame(0, vecs[v].m, 4, eq);
      compareRun($sformatf("vec%0d", v));
      frames_done++;
      checkFrameCnt();
    end

    $display("[TB] underrun");
    sub_mode = 1'b0;
    bq = '{8'h3C, 8'hC3};
    applyStimulus(bq, 0, 1'b0);
    waitIdle("underrun");
    checkOutput("underrun err set", 32'(err_underrun), 32'd1);
    checkOutput("underrun busy low", 32'(busy), 32'd0);
    buildFrame(0, 1'b0, 2, bq);
    compareRun("underrun");
    checkFrameCnt();
    pulseErrClr();
    checkOutput("err_clr clears", 32'(err_underrun), 32'd0);

    $display("[TB] underrun with err_clr held");
    err_clr = 1'b1;
    sub_mode = 1'b1;
    bq = '{8'h5A, 8'hA5};
    eq = '{ref_result(1'b1, 8'h5A), ref_result(1'b1, 8'hA5)};
    applyStimulus(bq, 0, 1'b0);
    waitIdle("setwins");
    buildFrame(0, 1'b1, 2, eq);
    compareRun("setwins");
    checkOutput("setwins cleared after", 32'(err_underrun), 32'd0);
    err_clr = 1'b0;

    $display("[TB] back-to-back");
    for (int r = 0; r < 2; r++) begin
      m = r[0];
      sub_mode = m;
      bq.delete(); eq.delete(); eq2.delete();
      for (int j = 0; j < 8; j++) bq.push_back(8'($urandom));
      for (int j = 0; j < 4; j++) eq.push_back(ref_result(m, bq[j]));
      for (int j = 4; j < 8; j++) eq2.push_back(ref_result(m, bq[j]));
      applyStimulus(bq, 0, 1'b0);
      waitIdle("b2b");
      if (fall_t.size() > 0 && start_t.size() > 1)
        checkOutput("b2b idle gap", 32'(start_t[1] - fall_t[0]), 32'd1);
      else
        checkOutput("b2b two frames seen", 32'(start_t.size()), 32'd2);
      buildFrame(0, m, 4, eq);
      buildFrame(1, m, 4, eq2);
      compareRun($sformatf("b2b%0d", r));
      frames_done += 2;
      checkFrameCnt();
    end

    $display("[TB] random frames");
    for (int r = 0; r < 20; r++) begin
      m = 1'($urandom);
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : N;
      if (err_underrun) pulseErrClr();
      sub_mode = m;
      bq.delete(); eq.delete();
      for (int j = 0; j < k; j++) begin
        bq.push_back(8'($urandom));
        eq.push_back(ref_result(m, bq[j]));
      end
      applyStimulus(bq, 3, 1'($urandom));
      waitIdle($sformatf("rnd%0d", r));
      checkOutput($sformatf("rnd%0d err", r), 32'(err_underrun), 32'(k < N));
      buildFrame(0, m, k, eq);
      compareRun($sformatf("rnd%0d", r));
      if (k == N) frames_done++;
      checkFrameCnt();
    end
    if (err_underrun) pulseErrClr();

    $display("[TB] reset mid-frame");
    sub_mode = 1'b1;
    bq = '{8'h12, 8'h34, 8'h56, 8'h78};
    fork
      applyStimulus(bq, 0, 1'b0);
      begin
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        checkOutput("reset test frame started", 32'(busy), 32'd1);
        repeat (19) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset out_data", 32'(out_data), 32'd0);
        checkOutput("midreset ser_bit", 32'(ser_bit), 32'd0);
        checkOutput("midreset sbox_en", 32'(sbox_en), 32'd0);
      end
    join
    clearRecords();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no output after reset", 32'(out_q.size()), 32'd0);
    frames_done = 0;
    checkFrameCnt();
    clearRecords();

    for (int r = 0; r < 3; r++) begin
      m = 1'($urandom);
      sub_mode = m;
      bq.delete(); eq.delete();
      for (int j = 0; j < 4; j++) begin
        bq.push_back(8'($urandom));
        eq.push_back(ref_result(m, bq[j]));
      end
      applyStimulus(bq, 1, 1'b0);
      waitIdle("post-reset");
      buildFrame(0, m, 4, eq);
      compareRun($sformatf("postreset%0d", r));
      frames_done++;
      checkFrameCnt();
    end
    sub_mode = 1'b0;
    bq = '{8'h99, 8'h66, 8'hAA};
    applyStimulus(bq, 0, 1'b0);
    waitIdle("aborted");
    buildFrame(0, 1'b0, 3, bq);
    compareRun("aborted");
    checkFrameCnt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
